div_issue_ctrl: RTL



---
 rtl/div_pkg.sv | 16 +
 rtl/div_core.sv | 105 ++++++++++
 rtl/div_issue_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the lane-shared divider
package div_pkg;

  localparam int DIV_ITER = 32;

  localparam int DIV_SIGNED_BIT = 0;
  localparam int DIV_REM_BIT    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - radix-2 restoring divider with sign fixup and zero-divisor bypass
module div_core
  import div_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = DIV_ITER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam logic [5:0] ITER_CNT = 6'(ITER);

  logic [XLEN:0]   r_r;
  logic [XLEN-1:0] q_r;
  logic [XLEN-1:0] d_r;
  logic [5:0]      cnt_r;
  logic            busy_r;
  logic            neg_q_r;
  logic            neg_r_r;
  logic            dz_r;

  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN:0]   r_sh;
  logic            ge;

  // Operand magnitudes and one restoring step on the shifted partial remainder
  always_comb begin
    mag1 = (is_signed && src1[XLEN-1]) ? (~src1 + 1'b1) : src1;
    mag2 = (is_signed && src2[XLEN-1]) ? (~src2 + 1'b1) : src2;
    r_sh = {r_r[XLEN-1:0], q_r[XLEN-1]};
    // r_r stays below the divisor, so its top bit only matters if that invariant breaks
    ge   = r_r[XLEN] || (r_sh >= {1'b0, d_r});
  end

  // Load on start, iterate while the counter runs, drop busy once done is seen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r     <= '0;
      q_r     <= '0;
      d_r     <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
    end else if (abort) begin
      busy_r <= 1'b0;
      cnt_r  <= '0;
    end else if (start) begin
      busy_r  <= 1'b1;
      neg_q_r <= is_signed && (src1[XLEN-1] ^ src2[XLEN-1]);
      d_r     <= mag2;
      if (src2 == '0) begin
        // Zero divisor: no iterations, remainder is the raw dividend
        dz_r    <= 1'b1;
        cnt_r   <= '0;
        r_r     <= {1'b0, src1};
        q_r     <= '0;
        neg_r_r <= 1'b0;
      end else begin
        dz_r    <= 1'b0;
        cnt_r   <= ITER_CNT;
        r_r     <= '0;
        q_r     <= mag1;
        neg_r_r <= is_signed && src1[XLEN-1];
      end
    end else if (busy_r) begin
      if (cnt_r != '0) begin
        cnt_r <= cnt_r - 6'd1;
        if (ge) begin
          r_r <= r_sh - {1'b0, d_r};
          q_r <= {q_r[XLEN-2:0], 1'b1};
        end else begin
          r_r <= r_sh;
          q_r <= {q_r[XLEN-2:0], 1'b0};
        end
      end else begin
        busy_r <= 1'b0;
      end
    end
  end

  // Sign fixup applied to the final magnitudes
  always_comb begin
    busy = busy_r;
    done = busy_r && (cnt_r == '0);
    if (dz_r)
      quot = '1;
    else
      quot = neg_q_r ? (~q_r + 1'b1) : q_r;
    rem = neg_r_r ? (~r_r[XLEN-1:0] + 1'b1) : r_r[XLEN-1:0];
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - sequences one shared divider across issue lanes A and B
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = DIV_ITER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall_dcache,
  input  logic            EX_br_a,
  input  logic            EX_div_req_a,
  input  logic            EX_div_req_b,
  input  logic [1:0]      EX_div_op_a,
  input  logic [1:0]      EX_div_op_b,
  input  logic [XLEN-1:0] EX_src1_a,
  input  logic [XLEN-1:0] EX_src2_a,
  input  logic [XLEN-1:0] EX_src1_b,
  input  logic [XLEN-1:0] EX_src2_b,
  output logic            stall_div,
  output logic [XLEN-1:0] EX_div_result_a,
  output logic [XLEN-1:0] EX_div_result_b,
  output logic            EX_div_valid_a,
  output logic            EX_div_valid_b
);

  div_state_t state;
  logic       served_a;

  logic            req_b_ok;
  logic            new_req;
  logic            sel_b;
  logic            core_start;
  logic            core_signed;
  logic [XLEN-1:0] core_src1;
  logic [XLEN-1:0] core_src2;
  logic            core_busy;
  logic            core_done;
  logic [XLEN-1:0] core_quot;
  logic [XLEN-1:0] core_rem;
  logic [XLEN-1:0] sel_res_a;
  logic [XLEN-1:0] sel_res_b;

  // Lane selection, core start and pipeline hold
  always_comb begin
    req_b_ok    = EX_div_req_b && !EX_br_a;
    new_req     = EX_div_req_a || req_b_ok;
    sel_b       = (state == RUN_A) || ((state == IDLE) && !EX_div_req_a);
    core_start  = !flush && (((state == IDLE) && new_req) ||
                             ((state == RUN_A) && core_done && req_b_ok));
    core_signed = sel_b ? EX_div_op_b[DIV_SIGNED_BIT] : EX_div_op_a[DIV_SIGNED_BIT];
    core_src1   = sel_b ? EX_src1_b : EX_src1_a;
    core_src2   = sel_b ? EX_src2_b : EX_src2_a;
    stall_div   = !flush && (((state == IDLE) && new_req) || core_busy ||
                             (state == RUN_A) || (state == RUN_B));
    sel_res_a   = EX_div_op_a[DIV_REM_BIT] ? core_rem : core_quot;
    sel_res_b   = EX_div_op_b[DIV_REM_BIT] ? core_rem : core_quot;
  end

  div_core #(
    .XLEN (XLEN),
    .ITER (ITER)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush),
    .start     (core_start),
    .is_signed (core_signed),
    .src1      (core_src1),
    .src2      (core_src2),
    .busy      (core_busy),
    .done      (core_done),
    .quot      (core_quot),
    .rem       (core_rem)
  );

  // Issue FSM with registered results and valid flags
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state           <= IDLE;
      served_a        <= 1'b0;
      EX_div_valid_a  <= 1'b0;
      EX_div_valid_b  <= 1'b0;
      EX_div_result_a <= '0;
      EX_div_result_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          served_a <= 1'b0;
          if (EX_div_req_a)
            state <= RUN_A;
          else if (req_b_ok)
            state <= RUN_B;
        end
        RUN_A: begin
          if (core_done) begin
            EX_div_result_a <= sel_res_a;
            if (req_b_ok) begin
              served_a <= 1'b1;
              state    <= RUN_B;
            end else begin
              EX_div_valid_a <= 1'b1;
              state          <= DONE;
            end
          end
        end
        RUN_B: begin
          if (core_done) begin
            EX_div_result_b <= sel_res_b;
            EX_div_valid_b  <= 1'b1;
            EX_div_valid_a  <= served_a;
            state           <= DONE;
          end
        end
        DONE: begin
          // The instruction stays presented until this edge, so requests are ignored here
          if (!stall_dcache) begin
            EX_div_valid_a <= 1'b0;
            EX_div_valid_b <= 1'b0;
            served_a       <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
